fp_result_normalizer: RTL and testbench



---
 rtl/fp_result_normalizer.sv | 143 ++++++++++++++
 tb/tb_fp_result_normalizer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_result_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_normalizer
// Purpose  : Post-add normalizer for the single-precision FP adder. Takes the
//            raw mantissa sum (carry, hidden, fraction) and the common
//            exponent, and walks it back to 1.f form one step per cycle,
//            handling carry-out, zero, overflow to infinity and underflow
//            (flush to signed zero). Rounding is truncation only.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            in_valid/ready  - upstream handshake (accept only in IDLE)
//            in_sign/exp/mant- raw sum; in_mant[MANT_W+1] carry,
//                              in_mant[MANT_W] hidden, rest fraction
//            out_valid/ready - downstream handshake (valid only in DONE)
//            out_sign/exp/mant - normalized result, hidden bit dropped
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_normalizer #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] C_EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] C_EXP_ONE  = EXP_W'(1);

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W+1:0]   mant_q, mant_d;
  logic                osign_q, osign_d;
  logic [EXP_W-1:0]    oexp_q, oexp_d;
  logic [MANT_W-1:0]   omant_q, omant_d;
  logic [EXP_W-1:0]    exp_inc;

  assign exp_inc = exp_q + C_EXP_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      osign_q <= 1'b0;
      oexp_q  <= '0;
      omant_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      osign_q <= osign_d;
      oexp_q  <= oexp_d;
      omant_q <= omant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    osign_d = osign_q;
    oexp_d  = oexp_q;
    omant_d = omant_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Rules are prioritised: specials first, then zero, carry, normalized,
        // underflow; only the final fall-through keeps iterating.
        osign_d = sign_q;
        if (exp_q == C_EXP_ONES) begin
          oexp_d  = exp_q;
          omant_d = mant_q[MANT_W-1:0];
          state_d = DONE;
        end else if ((mant_q == '0) || (exp_q == '0)) begin
          oexp_d  = '0;
          omant_d = '0;
          state_d = DONE;
        end else if (mant_q[MANT_W+1]) begin
          // Right shift drops the LSB; the old hidden bit becomes fraction MSB.
          oexp_d  = exp_inc;
          omant_d = (exp_inc == C_EXP_ONES) ? '0 : mant_q[MANT_W:1];
          state_d = DONE;
        end else if (mant_q[MANT_W]) begin
          oexp_d  = exp_q;
          omant_d = mant_q[MANT_W-1:0];
          state_d = DONE;
        end else if (exp_q <= C_EXP_ONE) begin
          // Another left shift would need a denormal; flush instead.
          oexp_d  = '0;
          omant_d = '0;
          state_d = DONE;
        end else begin
          mant_d = {mant_q[MANT_W:0], 1'b0};
          exp_d  = exp_q - C_EXP_ONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign out_sign  = osign_q;
  assign out_exp   = oexp_q;
  assign out_mant  = omant_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_result_normalizer
// Purpose  : Self-checking bench for fp_result_normalizer: table of directed
//            vectors with hand-computed results and latencies, plus
//            backpressure and mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_result_normalizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;

  int total;
  int bad;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic        xs;
    logic [7:0]  xe;
    logic [22:0] xm;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  fp_result_normalizer #(.EXP_W(8), .MANT_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one input, measures edges from accept to out_valid, checks the
  // result, then completes the handshake (out_ready held high).
  task automatic run_vec(input vec_t v, input string tag);
    int edges;
    @(negedge clk);
    in_valid  = 1'b1;
    in_sign   = v.s;
    in_exp    = v.e;
    in_mant   = v.m;
    out_ready = 1'b1;
    chk({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, " latency"}, 32'(edges), 32'(v.lat));
    chk({tag, " sign"}, 32'(out_sign), 32'(v.xs));
    chk({tag, " exp"}, 32'(out_exp), 32'(v.xe));
    chk({tag, " mant"}, 32'(out_mant), 32'(v.xm));
    @(posedge clk); #1;
    chk({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //           s     e      m            xs    xe     xm         lat
    vecs[0]  = '{1'b0, 8'h80, 25'h0C00000, 1'b0, 8'h80, 23'h400000, 2};  // normalized
    vecs[1]  = '{1'b0, 8'h80, 25'h1800001, 1'b0, 8'h81, 23'h400000, 2};  // carry, LSB lost
    vecs[2]  = '{1'b0, 8'h85, 25'h0100000, 1'b0, 8'h82, 23'h000000, 5};  // 3 left shifts
    vecs[3]  = '{1'b0, 8'hFE, 25'h1000000, 1'b0, 8'hFF, 23'h000000, 2};  // overflow -> inf
    vecs[4]  = '{1'b1, 8'h02, 25'h0000001, 1'b1, 8'h00, 23'h000000, 3};  // underflow after shift
    vecs[5]  = '{1'b1, 8'h40, 25'h0000000, 1'b1, 8'h00, 23'h000000, 2};  // zero mantissa
    vecs[6]  = '{1'b0, 8'hFF, 25'h0ABCDEF, 1'b0, 8'hFF, 23'h2BCDEF, 2};  // special passthrough
    vecs[7]  = '{1'b0, 8'h20, 25'h0000001, 1'b0, 8'h09, 23'h000000, 25}; // worst case 23 shifts
    vecs[8]  = '{1'b1, 8'h00, 25'h0C00000, 1'b1, 8'h00, 23'h000000, 2};  // zero exponent
    vecs[9]  = '{1'b0, 8'h01, 25'h0400000, 1'b0, 8'h00, 23'h000000, 2};  // immediate underflow
    vecs[10] = '{1'b1, 8'h10, 25'h1FFFFFF, 1'b1, 8'h11, 23'h7FFFFF, 2};  // carry all ones

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_exp", 32'(out_exp), 32'd0);
    chk("reset out_mant", 32'(out_mant), 32'd0);
    chk("reset out_sign", 32'(out_sign), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, new input refused.
    begin
      int edges;
      @(negedge clk);
      in_valid  = 1'b1;
      in_sign   = 1'b1;
      in_exp    = 8'h80;
      in_mant   = 25'h0C00000;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_sign = 1'b0;
      in_exp  = 8'h33;
      in_mant = 25'h1000000;   // stays valid to probe that it is refused
      edges = 1;
      while (!out_valid && edges < 10) begin
        @(posedge clk); #1;
        edges++;
      end
      chk("bp latency", 32'(edges), 32'd2);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        chk("bp out_valid held", 32'(out_valid), 32'd1);
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        chk("bp stable", {out_sign, out_exp, out_mant}, {1'b1, 8'h80, 23'h400000});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp released out_valid", 32'(out_valid), 32'd0);
      chk("bp released in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp no ghost accept", 32'(in_ready), 32'd1);
    end

    // Asynchronous reset during the second left shift of a 5-shift input.
    begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sign   = 1'b0;
      in_exp    = 8'h90;
      in_mant   = 25'h0040000;
      out_ready = 1'b1;
      @(posedge clk); #1;       // accept edge
      in_valid = 1'b0;
      @(posedge clk); #1;       // first shift done
      @(posedge clk); #3;       // second shift done, mid-cycle
      rst = 1'b1;
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_exp", 32'(out_exp), 32'd0);
      chk("rst out_mant", 32'(out_mant), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst held in_ready", 32'(in_ready), 32'd0);
      chk("rst held out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst released in_ready", 32'(in_ready), 32'd1);
      run_vec('{1'b0, 8'h90, 25'h0040000, 1'b0, 8'h8B, 23'h000000, 7}, "after_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
